// File: rtl/kp_inc_gen_pkg.sv
// Shared definitions for the Kp increment generator: FSM encoding, data widths, abs helper.
package kp_inc_gen_pkg;

  localparam int unsigned ERR_W = 8;
  localparam int unsigned INC_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    DECIDE = 3'd2,
    EMIT   = 3'd3,
    HLD    = 3'd4
  } state_t;

  // Magnitude of a signed 8-bit sample as unsigned 8-bit, so |-128| = 128.
  function automatic logic [ERR_W-1:0] abs_err(input logic [ERR_W-1:0] v);
    abs_err = v[ERR_W-1] ? ERR_W'(~v + ERR_W'(1)) : v;
  endfunction

endpackage

// File: rtl/kp_err_window.sv
// Per-window statistics: sample count, |err| accumulator and sign-change counter.
module kp_err_window
  import kp_inc_gen_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    accept,
  input  logic [ERR_W-1:0]        err,
  output logic                    done,
  output logic [WIN_LOG2+7:0]     abs_acc,
  output logic [WIN_LOG2-1:0]     osc_cnt
);

  localparam int unsigned ACC_W = WIN_LOG2 + 8;
  localparam int unsigned CNT_W = WIN_LOG2 + 1;
  localparam logic [WIN_LOG2-1:0] OSC_MAX = '1;

  logic [CNT_W-1:0] smp_cnt;
  logic             prev_sign;

  // Window is full once the counter reaches 2**WIN_LOG2.
  assign done = smp_cnt[CNT_W-1];

  // Accumulate accepted samples; first sample of a window only seeds the sign tracker.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      smp_cnt   <= '0;
      abs_acc   <= '0;
      osc_cnt   <= '0;
      prev_sign <= 1'b0;
    end else if (accept) begin
      smp_cnt   <= smp_cnt + CNT_W'(1);
      abs_acc   <= abs_acc + ACC_W'(abs_err(err));
      prev_sign <= err[ERR_W-1];
      if ((smp_cnt != '0) && (err[ERR_W-1] != prev_sign) && (osc_cnt != OSC_MAX))
        osc_cnt <= osc_cnt + WIN_LOG2'(1);
    end
  end

endmodule

// File: rtl/kp_inc_gen.sv
// Kp gain-increment generator: one signed increment pulse per observation window.
// Optional build macro KPINC_STEP_SCALE_EN doubles the positive step when the
// window mean reaches twice ERR_THRESH.
module kp_inc_gen
  import kp_inc_gen_pkg::*;
#(
  parameter int unsigned WIN_LOG2   = 4,
  parameter int unsigned STEP       = 1,
  parameter int unsigned ERR_THRESH = 8,
  parameter int unsigned OSC_LIMIT  = 6,
  parameter int unsigned HOLDOFF    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [ERR_W-1:0] err,
  input  logic             err_valid,
  output logic [INC_W-1:0] inc,
  output logic             holdoff
);

  localparam int unsigned ACC_W  = WIN_LOG2 + 8;
  localparam int unsigned HCNT_W = 8;

  state_t               state;
  logic [HCNT_W-1:0]    hcnt;
  logic                 win_done;
  logic [ACC_W-1:0]     abs_acc;
  logic [WIN_LOG2-1:0]  osc_cnt;
  logic [ACC_W-1:0]     mean_c;
  logic [INC_W-1:0]     next_inc_c;
  logic                 win_clr_c;
  logic                 win_accept_c;

  // Window is cleared whenever it is not actively collecting; full windows stop accepting.
  assign win_clr_c    = !en || (state != ACCUM);
  assign win_accept_c = en && (state == ACCUM) && err_valid && !win_done;

  kp_err_window #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_win (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (win_clr_c),
    .accept  (win_accept_c),
    .err     (err),
    .done    (win_done),
    .abs_acc (abs_acc),
    .osc_cnt (osc_cnt)
  );

  // Increment decision for a full window; oscillation takes priority over large error.
  always_comb begin
    mean_c     = abs_acc >> WIN_LOG2;
    next_inc_c = '0;
    if (osc_cnt >= WIN_LOG2'(OSC_LIMIT)) begin
      next_inc_c = -INC_W'(STEP);
    end else if (mean_c >= ACC_W'(ERR_THRESH)) begin
`ifdef KPINC_STEP_SCALE_EN
      if (mean_c >= ACC_W'(2 * ERR_THRESH))
        next_inc_c = INC_W'(2 * STEP);
      else
        next_inc_c = INC_W'(STEP);
`else
      next_inc_c = INC_W'(STEP);
`endif
    end
  end

  // Control FSM with registered inc pulse and holdoff counter.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      state   <= IDLE;
      inc     <= '0;
      holdoff <= 1'b0;
      hcnt    <= '0;
    end else begin
      case (state)
        IDLE: state <= ACCUM;
        ACCUM: begin
          if (win_done) state <= DECIDE;
        end
        DECIDE: begin
          if (next_inc_c != '0) begin
            inc   <= next_inc_c;
            state <= EMIT;
          end else begin
            state <= ACCUM;
          end
        end
        EMIT: begin
          inc     <= '0;
          holdoff <= 1'b1;
          hcnt    <= HCNT_W'(HOLDOFF - 1);
          state   <= HLD;
        end
        HLD: begin
          if (hcnt == '0) begin
            holdoff <= 1'b0;
            state   <= ACCUM;
          end else begin
            hcnt <= hcnt - HCNT_W'(1);
          end
        end
        default: begin
          inc     <= '0;
          holdoff <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kp_inc_gen.sv
// Directed self-checking bench for kp_inc_gen (default parameters).
module tb_kp_inc_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] err;
  logic       err_valid;
  logic [7:0] inc;
  logic       holdoff;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  kp_inc_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .err       (err),
    .err_valid (err_valid),
    .inc       (inc),
    .holdoff   (holdoff)
  );

  always #5 clk = ~clk;

  // Counts cycles with a nonzero increment, sampled mid-cycle.
  always @(negedge clk) if (inc != 8'h00) pulses++;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) begin
      err = v; err_valid = 1'b1;
      tick();
    end
    err_valid = 1'b0;
  endtask

  task automatic send_alt(input int n, input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      err = (i % 2 == 0) ? a : b; err_valid = 1'b1;
      tick();
    end
    err_valid = 1'b0;
  endtask

  // Ride out holdoff while injecting samples; returns number of holdoff cycles seen.
  task automatic wait_holdoff(output int cyc);
    cyc = holdoff ? 1 : 0;
    for (int i = 0; i < 100 && holdoff; i++) begin
      err = 8'h80; err_valid = 1'b1;
      tick();
      if (holdoff) cyc++;
    end
    err_valid = 1'b0;
  endtask

  int p0;
  int hcyc;
  int incv;

  initial begin
    rst_n = 1'b0; en = 1'b1; err = 8'd20; err_valid = 1'b0;

    // 1: reset with en high and err_valid toggling
    for (int i = 0; i < 2; i++) begin
      err_valid = ~err_valid;
      tick();
      check("rst_inc", int'(inc), 0);
      check("rst_holdoff", int'(holdoff), 0);
    end
    rst_n = 1'b1; err_valid = 1'b0;
    tick();

    // 2: sixteen +20 samples -> +1 two cycles after the last sample
    p0 = pulses;
    send(16, 8'd20);
    check("t2_lat0", int'(inc), 0);
    tick();
    check("t2_lat1", int'(inc), 0);
    tick();
    check("t2_pulse", int'(inc), 1);
    tick();
    check("t2_clear", int'(inc), 0);
    check("t2_hold_on", int'(holdoff), 1);
    wait_holdoff(hcyc);
    check("t2_hold_len", hcyc, 32);
    check("t2_one_pulse", pulses - p0, 1);

    // 4: small error window, no pulse, next window accepted immediately
    p0 = pulses;
    send(16, 8'd2);
    repeat (4) tick();
    check("t4_no_pulse", pulses - p0, 0);
    check("t4_no_hold", int'(holdoff), 0);
    send(16, 8'd0);
    repeat (4) tick();
    check("t4_zero_no_pulse", pulses - p0, 0);

    // 3: alternating +3/-3 -> -1 despite small mean
    p0 = pulses;
    send_alt(16, 8'd3, 8'hFD);
    tick(); tick();
    check("t3_pulse", int'(inc), 255);
    tick();
    check("t3_clear", int'(inc), 0);
    wait_holdoff(hcyc);
    check("t3_hold_len", hcyc, 32);
    check("t3_one_pulse", pulses - p0, 1);

    // 5: -128 window, mean 128
`ifdef KPINC_STEP_SCALE_EN
    incv = 2;
`else
    incv = 1;
`endif
    send(16, 8'h80);
    tick(); tick();
    check("t5_pulse", int'(inc), incv);
    tick();
    wait_holdoff(hcyc);
    check("t5_hold_len", hcyc, 32);

    // 6: en drop mid-window discards the partial window
    p0 = pulses;
    send(7, 8'd20);
    en = 1'b0;
    tick();
    check("t6_en_off_inc", int'(inc), 0);
    en = 1'b1;
    tick();
    send(9, 8'd20);
    repeat (4) tick();
    check("t6_partial_no_pulse", pulses - p0, 0);
    send(7, 8'd20);
    tick(); tick();
    check("t6_fresh_pulse", int'(inc), 1);
    tick();
    check("t6_hold_on", int'(holdoff), 1);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check("t6_rst_holdoff", int'(holdoff), 0);
    check("t6_rst_inc", int'(inc), 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("t6_after_rst_holdoff", int'(holdoff), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
